// File: rtl/ibex_fetch_stage.sv
// Instruction fetch stage: next-PC selection, req/gnt/rvalid bus master,
// response FIFO and the IF/ID pipeline register feeding decode.
// Only 32-bit instructions are fetched; there is no compressed support.
module ibex_fetch_stage #(
    parameter int unsigned DEPTH        = 2,
    parameter logic [31:0] DM_HALT_ADDR = 32'h1A11_0800,
    parameter logic [31:0] DM_EXC_ADDR  = 32'h1A11_0808
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        pc_set_i,
    input  logic [2:0]  pc_mux_i,
    input  logic [1:0]  exc_pc_mux_i,
    input  logic [5:0]  exc_cause_i,
    input  logic [31:0] boot_addr_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_depc_i,
    input  logic        id_in_ready_i,
    input  logic        instr_valid_clear_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic        instr_fetch_err_o,
    output logic [31:0] pc_id_o,
    output logic        if_busy_o
);

    // Counters are 3 bits wide so they can hold the largest DEPTH (4).
    localparam int unsigned CW      = 3;
    localparam logic [3:0]  DEPTH_L = 4'(DEPTH);

    // One buffered instruction word with its error flag and fetch PC.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] pc;
    } fifo_entry_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [31:0]   r_fetch_addr;
    logic          r_misalign;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_fifo_count;
    fifo_entry_t   r_fifo [DEPTH];
    logic [31:0]   r_pcq  [DEPTH];

    logic          r_instr_valid;
    logic [31:0]   r_instr_rdata;
    logic          r_fetch_err;
    logic [31:0]   r_pc_id;

    // ---------------------------------------------------------------
    // Combinational nets
    // ---------------------------------------------------------------
    logic [31:0]   w_target;
    logic          w_misaligned;
    logic [3:0]    w_sum;
    logic          w_req;
    logic          w_gnt_acc;
    logic          w_rsp_acc;
    logic          w_push;
    logic          w_load;
    logic [CW-1:0] w_fifo_wr_idx;
    logic [CW-1:0] w_pcq_wr_idx;
    fifo_entry_t   w_fifo_new;
    fifo_entry_t   w_fifo_shift [DEPTH];
    fifo_entry_t   w_fifo_nxt   [DEPTH];
    logic [31:0]   w_pcq_shift  [DEPTH];
    logic [31:0]   w_pcq_nxt    [DEPTH];
    logic          w_unused_bits;

    // Bits of the inputs that the address formation never looks at.
    assign w_unused_bits = ^{exc_cause_i[5], csr_mtvec_i[7:0], boot_addr_i[7:0]};

    // Redirect target selection from the controller's PC mux commands.
    always_comb begin
        w_target = {boot_addr_i[31:8], 8'h80};
        case (pc_mux_i)
            3'd0: w_target = {boot_addr_i[31:8], 8'h80};
            3'd1: w_target = jump_target_i;
            3'd2: begin
                case (exc_pc_mux_i)
                    2'd0:    w_target = {csr_mtvec_i[31:8], 8'h00};
                    2'd1:    w_target = {csr_mtvec_i[31:8], 1'b0, exc_cause_i[4:0], 2'b00};
                    2'd2:    w_target = DM_HALT_ADDR;
                    2'd3:    w_target = DM_EXC_ADDR;
                    default: w_target = DM_HALT_ADDR;
                endcase
            end
            3'd3:    w_target = csr_mepc_i;
            3'd4:    w_target = csr_depc_i;
            default: w_target = {boot_addr_i[31:8], 8'h80};
        endcase
    end

    assign w_misaligned = (w_target[1:0] != 2'b00);

    // Requests stop when in-flight plus buffered words would exceed the FIFO.
    assign w_sum     = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign w_req     = rst_ni & req_i & ~pc_set_i & ~r_misalign & (w_sum < DEPTH_L);
    assign w_gnt_acc = w_req & instr_gnt_i;
    // A response with nothing outstanding is a bus protocol error; ignore it.
    assign w_rsp_acc = instr_rvalid_i & (r_outstanding != 3'd0);
    assign w_push    = w_rsp_acc & (r_discard == 3'd0) & ~pc_set_i;
    assign w_load    = id_in_ready_i & (r_fifo_count != 3'd0) & ~pc_set_i;

    assign w_fifo_wr_idx = r_fifo_count - {2'b00, w_load};
    assign w_pcq_wr_idx  = r_outstanding - {2'b00, w_rsp_acc};

    assign w_fifo_new.rdata = instr_rdata_i;
    assign w_fifo_new.err   = instr_err_i;
    assign w_fifo_new.pc    = r_pcq[0];

    // Response FIFO next state: shift out the head on load, write at the tail on push.
    always_comb begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            w_fifo_shift[i] = w_load ? r_fifo[i+1] : r_fifo[i];
        end
        w_fifo_shift[DEPTH-1] = r_fifo[DEPTH-1];
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_fifo_nxt[i] = (w_push && (w_fifo_wr_idx == 3'(i))) ? w_fifo_new : w_fifo_shift[i];
        end
    end

    // Per-request PC queue next state: pop on response, append the granted address.
    always_comb begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            w_pcq_shift[i] = w_rsp_acc ? r_pcq[i+1] : r_pcq[i];
        end
        w_pcq_shift[DEPTH-1] = r_pcq[DEPTH-1];
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_pcq_nxt[i] = (w_gnt_acc && (w_pcq_wr_idx == 3'(i))) ? r_fetch_addr : w_pcq_shift[i];
        end
    end

    // Fetch address: reload on redirect, advance one word per granted request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fetch_addr <= {boot_addr_i[31:8], 8'h80};
        end else if (pc_set_i) begin
            r_fetch_addr <= w_target;
        end else if (w_gnt_acc) begin
            r_fetch_addr <= r_fetch_addr + 32'd4;
        end else begin
            r_fetch_addr <= r_fetch_addr;
        end
    end

    // Misaligned-target stall flag, held until the controller redirects again.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_misalign <= 1'b0;
        end else if (pc_set_i) begin
            r_misalign <= w_misaligned;
        end else begin
            r_misalign <= r_misalign;
        end
    end

    // Outstanding request counter; a grant and a response in one cycle cancel.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_outstanding <= 3'd0;
        end else begin
            r_outstanding <= r_outstanding + {2'b00, w_gnt_acc} - {2'b00, w_rsp_acc};
        end
    end

    // Discard counter: responses still owed to requests issued before a redirect.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_discard <= 3'd0;
        end else if (pc_set_i) begin
            r_discard <= r_outstanding - {2'b00, w_rsp_acc};
        end else if (w_rsp_acc && (r_discard != 3'd0)) begin
            r_discard <= r_discard - 3'd1;
        end else begin
            r_discard <= r_discard;
        end
    end

    // Response FIFO storage; a redirect flushes it and may plant a misalign error entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fifo_count <= 3'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
        end else if (pc_set_i) begin
            if (w_misaligned) begin
                r_fifo_count    <= 3'd1;
                r_fifo[0].rdata <= 32'h0000_0000;
                r_fifo[0].err   <= 1'b1;
                r_fifo[0].pc    <= w_target;
            end else begin
                r_fifo_count <= 3'd0;
            end
        end else begin
            r_fifo_count <= r_fifo_count + {2'b00, w_push} - {2'b00, w_load};
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo[i] <= w_fifo_nxt[i];
            end
        end
    end

    // PC queue storage, kept in step with the outstanding counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pcq[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pcq[i] <= w_pcq_nxt[i];
            end
        end
    end

    // IF/ID register: a load from the FIFO wins over an invalidate request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_instr_valid <= 1'b0;
            r_instr_rdata <= 32'h0000_0000;
            r_fetch_err   <= 1'b0;
            r_pc_id       <= 32'h0000_0000;
        end else if (pc_set_i) begin
            r_instr_valid <= 1'b0;
        end else if (w_load) begin
            r_instr_valid <= 1'b1;
            r_instr_rdata <= r_fifo[0].rdata;
            r_fetch_err   <= r_fifo[0].err;
            r_pc_id       <= r_fifo[0].pc;
        end else if (instr_valid_clear_i) begin
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= r_instr_valid;
        end
    end

    assign instr_req_o       = w_req;
    assign instr_addr_o      = {r_fetch_addr[31:2], 2'b00};
    assign instr_valid_id_o  = r_instr_valid;
    assign instr_rdata_id_o  = r_instr_rdata;
    assign instr_fetch_err_o = r_fetch_err;
    assign pc_id_o           = r_pc_id;
    assign if_busy_o         = (r_outstanding != 3'd0);

endmodule

// File: doc/ibex_fetch_stage.md
Name: ibex_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the core controller and decode stage.
- Selects the next PC from the controller's pc_set/pc_mux/exc_pc_mux commands and fetches aligned 32-bit words over a req/gnt/rvalid instruction bus, buffering responses in a small FIFO.
- Presents one instruction per cycle to ID through the IF/ID register: instr_valid, instr_rdata, fetch_err and pc_id, which the controller consumes.
- Without C-extension support; all instructions are 32-bit.

Parameters:
DEPTH, 2, max outstanding requests plus buffered words (FIFO entries), 2..4
DM_HALT_ADDR, 32'h1A110800, debug-mode entry address (EXC_PC_DBD)
DM_EXC_ADDR, 32'h1A110808, exception-in-debug address (EXC_PC_DBG_EXC)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_i  in  1  fetch enable from controller (its instr_req_o)
pc_set_i  in  1  redirect PC this cycle
pc_mux_i  in  3  0 BOOT, 1 JUMP, 2 EXC, 3 ERET, 4 DRET
exc_pc_mux_i  in  2  0 EXC, 1 IRQ, 2 DBD, 3 DBG_EXC
exc_cause_i  in  6  cause, used for vectored IRQ offset
boot_addr_i  in  32  boot base
jump_target_i  in  32  branch/jump target from EX
csr_mtvec_i  in  32  trap vector base
csr_mepc_i  in  32  mret target
csr_depc_i  in  32  dret target
id_in_ready_i  in  1  ID accepts a new instruction
instr_valid_clear_i  in  1  invalidate IF/ID register
instr_req_o  out  1  bus request
instr_addr_o  out  32  bus address, word aligned
instr_gnt_i  in  1  bus grant
instr_rvalid_i  in  1  response valid
instr_rdata_i  in  32  response data
instr_err_i  in  1  response error
instr_valid_id_o  out  1  IF/ID valid
instr_rdata_id_o  out  32  IF/ID instruction
instr_fetch_err_o  out  1  IF/ID fetch error
pc_id_o  out  32  IF/ID PC
if_busy_o  out  1  outstanding requests non-zero

Behaviour:
- Reset (rst_ni low at clk edge):
  - fetch_addr = {boot_addr_i[31:8],8'h80}.
  - FIFO empty; outstanding = 0; discard = 0.
  - All outputs 0, except instr_addr_o, which reflects fetch_addr.
- Target select on pc_set_i:
  - BOOT: {boot_addr_i[31:8],8'h80}.
  - JUMP: jump_target_i.
  - ERET: csr_mepc_i.
  - DRET: csr_depc_i.
  - EXC with exc_pc_mux EXC: {mtvec[31:8],8'h00}.
  - EXC with exc_pc_mux IRQ: {mtvec[31:8],1'b0,exc_cause_i[4:0],2'b00}.
  - EXC with exc_pc_mux DBD: DM_HALT_ADDR.
  - EXC with exc_pc_mux DBG_EXC: DM_EXC_ADDR.
  - pc_mux values 5..7: treated as BOOT.
- Redirect at cycle N:
  - fetch_addr <= target; FIFO flushed; IF/ID valid <= 0.
  - discard <= outstanding minus (1 if rvalid in N).
  - instr_req_o forced 0 in N; first new request in N+1.
- Misaligned target (target[1:0] != 0): no bus request is issued. A single FIFO entry is inserted with err=1 and pc=target; fetching stalls until the next pc_set_i.
- Request rule: instr_req_o = req_i & ~pc_set_i & ~misalign_stall & (outstanding + fifo_count < DEPTH).
  - instr_addr_o = fetch_addr.
  - On req & gnt: fetch_addr += 4 (wraps mod 2^32); outstanding += 1.
  - Address is held stable while req is high without gnt, except on redirect.
- Response handling on rvalid:
  - outstanding -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {rdata, err, pc} to the FIFO. pc comes from an internal per-request PC queue.
  - A simultaneous gnt and rvalid leaves outstanding unchanged.
- IF/ID register:
  - At the edge where id_in_ready_i & FIFO non-empty: load the head and pop it. Valid becomes 1.
  - Otherwise, if instr_valid_clear_i: valid becomes 0.
  - Load takes priority over clear.
  - A FIFO write is visible at the head one cycle later. Best-case latency from rvalid to instr_valid_id_o is 2 cycles.
- fetch_err: rdata is passed through unchanged. The controller uses instr_fetch_err_o with pc_id_o as mtval.
- Error-free invariant: outstanding + fifo_count <= DEPTH at all times.
  - Protocol violations (rvalid with outstanding == 0) are ignored and the counter saturates at 0.
- if_busy_o = (outstanding != 0).
- A synchronous reset mid-burst drops all state. Responses arriving after reset to pre-reset requests are not tracked, so the bus must be reset concurrently.

Test Plan:
- Reset, then pc_set BOOT with boot_addr 0x0000_1000, req_i=1, gnt always 1, rvalid 1 cycle after gnt → addresses 0x1080, 0x1084, …; pc_id_o 0x1080 then 0x1084; valid first high 3 cycles after first gnt.
- Hold gnt 0 for 5 cycles with DEPTH=2 → instr_req_o stays 1 with address stable at 0x1080; once 2 outstanding and 0 popped (id_in_ready_i=0), instr_req_o drops.
- Two outstanding requests, then pc_set JUMP to 0x2000 in the same cycle as one rvalid → both old responses dropped; first pushed pc = 0x2000; instr_valid_id_o low until the new response.
- pc_set EXC/IRQ with mtvec 0x8000_0001 and cause 0x2B → next instr_addr_o = 0x8000_002C.
- rvalid with instr_err_i=1 at pc 0x1084 → instr_fetch_err_o=1, pc_id_o=0x1084; JUMP target 0x3002 → no bus request, fetch_err entry with pc 0x3002.
- instr_valid_clear_i=1 with the FIFO empty → valid 0 next cycle; clear together with id_in_ready_i and a non-empty FIFO → the new instruction is loaded and valid stays 1.
